nn_layer_sequencer: RTL and testbench

//  Control FSM for the shared NeuralNetwork MAC datapath. Per sample it runs the hidden layer, then the output layer,

---
 rtl/nn_pkg.sv | 22 ++
 rtl/nn_argmax_tracker.sv | 41 ++++
 rtl/nn_layer_sequencer.sv | 171 +++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and defaults for the NeuralNetwork layer sequencer and its helpers.
package nn_pkg;

  // Sequencer states: one neuron is MAC -> DRAIN -> ACT -> WRITE, one sample ends in REPORT.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAC    = 3'd1,
    S_DRAIN  = 3'd2,
    S_ACT    = 3'd3,
    S_WRITE  = 3'd4,
    S_REPORT = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  localparam int SCORE_W_DEF = 16;
  localparam int IN_AW_DEF   = 16;
  localparam int W_AW_DEF    = 12;

  // Neuron and class indices share one width; up to 256 neurons per layer.
  localparam int CLS_W = 8;

endpackage

// File: rtl/nn_argmax_tracker.sv
// Running argmax over the output-layer scores of one sample.
// best_idx is a look-ahead view: it already includes a write happening this
// cycle, so the sequencer can register the winner on the last write's edge.
module nn_argmax_tracker
  import nn_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr,
  input  logic [CLS_W-1:0]   idx,
  input  logic [SCORE_W-1:0] score,
  output logic [CLS_W-1:0]   best_idx
);

  logic signed [SCORE_W-1:0] best_q;
  logic        [CLS_W-1:0]   idx_q;
  logic                      take;

  // Index 0 always seeds the search; later scores must be strictly larger so
  // ties stay with the lowest index.
  assign take     = wr && ((idx == '0) || ($signed(score) > best_q));
  assign best_idx = take ? idx : idx_q;

  // Hold the best score and its index seen so far in this sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= '0;
      idx_q  <= '0;
    end else if (clr) begin
      best_q <= '0;
      idx_q  <= '0;
    end else if (take) begin
      best_q <= $signed(score);
      idx_q  <= idx;
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Control FSM for the shared MAC datapath: per sample, runs every hidden
// neuron, then every output neuron, then reports the argmax class.
// Addresses are produced by incremental counters; weights for both layers are
// contiguous in one flat space, so w_addr simply counts through a sample.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_SAMPLES = 750,
  parameter int N_IN        = 62,
  parameter int N_HID       = 30,
  parameter int N_OUT       = 10,
  parameter int IN_AW       = IN_AW_DEF,
  parameter int W_AW        = W_AW_DEF,
  parameter int SCORE_W     = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [IN_AW-1:0]   in_addr,
  output logic [W_AW-1:0]    w_addr,
  output logic               layer,
  output logic               mac_clr,
  output logic               mac_en,
  output logic [7:0]         neuron_idx,
  output logic               neuron_wr,
  input  logic [SCORE_W-1:0] score,
  output logic [7:0]         result,
  output logic               batch_done,
  output logic               busy,
  output logic               done
);

  localparam int FAN_MAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int FAN_W   = $clog2(FAN_MAX + 1);
  localparam int SMP_W   = $clog2(NUM_SAMPLES + 1);

  localparam logic [FAN_W-1:0] LAST_I_HID = FAN_W'(N_IN - 1);
  localparam logic [FAN_W-1:0] LAST_I_OUT = FAN_W'(N_HID - 1);
  localparam logic [CLS_W-1:0] LAST_N_HID = CLS_W'(N_HID - 1);
  localparam logic [CLS_W-1:0] LAST_N_OUT = CLS_W'(N_OUT - 1);
  localparam logic [SMP_W-1:0] LAST_SMP   = SMP_W'(NUM_SAMPLES - 1);
  localparam logic [IN_AW-1:0] IN_STRIDE  = IN_AW'(N_IN);

  state_t           state;
  logic [FAN_W-1:0] i_cnt;
  logic [CLS_W-1:0] n_cnt;
  logic [SMP_W-1:0] smp_cnt;
  logic [IN_AW-1:0] smp_base;
  logic             last_i;
  logic             last_n;
  logic             accept;
  logic [CLS_W-1:0] best_idx;

  // Fan-in and neuron count depend on which layer is running.
  assign last_i = (i_cnt == (layer ? LAST_I_OUT : LAST_I_HID));
  assign last_n = (n_cnt == (layer ? LAST_N_OUT : LAST_N_HID));
  // FIN is already not busy, so a start there is taken like in IDLE.
  assign accept = start && ((state == S_IDLE) || (state == S_FIN));

  nn_argmax_tracker #(
    .SCORE_W (SCORE_W)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .wr       (neuron_wr & layer),
    .idx      (neuron_idx),
    .score    (score),
    .best_idx (best_idx)
  );

  // Sequencer FSM with counters, address accumulators and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      i_cnt      <= '0;
      n_cnt      <= '0;
      smp_cnt    <= '0;
      smp_base   <= '0;
      in_addr    <= '0;
      w_addr     <= '0;
      layer      <= 1'b0;
      mac_clr    <= 1'b0;
      mac_en     <= 1'b0;
      neuron_idx <= '0;
      neuron_wr  <= 1'b0;
      result     <= '0;
      batch_done <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Memory has one cycle of latency, so the MAC strobes trail the address.
      mac_en     <= (state == S_MAC);
      mac_clr    <= (state == S_MAC) && (i_cnt == '0);
      neuron_wr  <= (state == S_ACT);
      neuron_idx <= n_cnt;
      batch_done <= 1'b0;

      if (accept) begin
        state    <= S_MAC;
        busy     <= 1'b1;
        done     <= 1'b0;
        smp_cnt  <= '0;
        smp_base <= '0;
        layer    <= 1'b0;
        n_cnt    <= '0;
        i_cnt    <= '0;
        in_addr  <= '0;
        w_addr   <= '0;
      end else begin
        unique case (state)
          S_IDLE: ;

          S_MAC: begin
            // w_addr always advances: the next neuron's weights follow directly.
            w_addr <= w_addr + 1'b1;
            if (last_i) begin
              state <= S_DRAIN;
            end else begin
              i_cnt   <= i_cnt + 1'b1;
              in_addr <= in_addr + 1'b1;
            end
          end

          S_DRAIN: state <= S_ACT;

          S_ACT: state <= S_WRITE;

          S_WRITE: begin
            i_cnt <= '0;
            if (!last_n) begin
              n_cnt   <= n_cnt + 1'b1;
              in_addr <= layer ? '0 : smp_base;
              state   <= S_MAC;
            end else if (!layer) begin
              layer   <= 1'b1;
              n_cnt   <= '0;
              in_addr <= '0;
              state   <= S_MAC;
            end else begin
              result     <= best_idx;
              batch_done <= 1'b1;
              state      <= S_REPORT;
            end
          end

          S_REPORT: begin
            if (smp_cnt == LAST_SMP) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              smp_cnt  <= smp_cnt + 1'b1;
              smp_base <= smp_base + IN_STRIDE;
              in_addr  <= smp_base + IN_STRIDE;
              w_addr   <= '0;
              layer    <= 1'b0;
              n_cnt    <= '0;
              state    <= S_MAC;
            end
          end

          S_FIN: state <= S_IDLE;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: a per-run timeline model built from nested
// sample/layer/neuron/input loops, compared against the DUT every cycle,
// plus literal timing, address and argmax expectations.
module tb_nn_layer_sequencer;

  localparam int NS     = 2;
  localparam int NI     = 3;
  localparam int NH     = 2;
  localparam int NO     = 3;
  localparam int IN_AW  = 16;
  localparam int W_AW   = 12;
  localparam int SW     = 16;
  localparam int T_DONE = 1 + NS * (NH * (NI + 3) + NO * (NH + 3) + 1);
  localparam int TLEN   = T_DONE + 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [IN_AW-1:0]  in_addr;
  logic [W_AW-1:0]   w_addr;
  logic              layer;
  logic              mac_clr;
  logic              mac_en;
  logic [7:0]        neuron_idx;
  logic              neuron_wr;
  logic [SW-1:0]     score;
  logic [7:0]        result;
  logic              batch_done;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  nn_layer_sequencer #(
    .NUM_SAMPLES (NS),
    .N_IN        (NI),
    .N_HID       (NH),
    .N_OUT       (NO),
    .IN_AW       (IN_AW),
    .W_AW        (W_AW),
    .SCORE_W     (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_addr    (in_addr),
    .w_addr     (w_addr),
    .layer      (layer),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .neuron_idx (neuron_idx),
    .neuron_wr  (neuron_wr),
    .score      (score),
    .result     (result),
    .batch_done (batch_done),
    .busy       (busy),
    .done       (done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected timeline of one run, indexed by cycles after the start cycle.
  bit            e_mac [TLEN];
  bit            e_en  [TLEN];
  bit            e_clr [TLEN];
  bit            e_wr  [TLEN];
  bit            e_bd  [TLEN];
  bit            e_busy[TLEN];
  bit            e_done[TLEN];
  bit            e_sc  [TLEN];
  int            e_ia  [TLEN];
  int            e_wa  [TLEN];
  int            e_lay [TLEN];
  int            e_idx [TLEN];
  int            e_bdv [TLEN];
  int            e_res [TLEN];
  logic [SW-1:0] sc_tab[TLEN];
  int            exp_final;
  int            prev_res  = 0;
  bit            prev_done = 1'b0;

  int  run_base = 0;
  bit  chk_on   = 1'b0;
  int  cap_ia[TLEN];
  int  cap_wa[TLEN];
  int  bd_t[$];
  int  bd_r[$];
  int  done_t;

  logic [SW-1:0] dir_a0[3] = '{16'h0005, 16'hFFFD, 16'h0005};
  logic [SW-1:0] dir_a1[3] = '{16'hFFF9, 16'hFFFE, 16'hFFF7};
  logic [SW-1:0] dir_b [3] = '{16'h8000, 16'h7FFF, 16'h0000};

  task automatic chk(input string nm, input int t, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s (t=%0d): got %0d, expected %0d", nm, t, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  function automatic logic [SW-1:0] pick_score(input int mode, input int s, input int n);
    logic [SW-1:0] v;
    case (mode)
      0:       v = (s == 0) ? dir_a0[n] : dir_a1[n];
      1:       v = (s == 0) ? dir_b[n] : SW'($urandom);
      3:       v = SW'($urandom_range(0, 2)) - SW'(1);
      default: v = SW'($urandom);
    endcase
    return v;
  endfunction

  task automatic build_model(input int mode);
    int t;
    int bidx;
    int cur;
    logic signed [SW-1:0] best;
    logic [SW-1:0] sc;
    for (int k = 0; k < TLEN; k++) begin
      e_mac[k] = 0; e_en[k] = 0; e_clr[k] = 0; e_wr[k] = 0; e_bd[k] = 0; e_sc[k] = 0;
      e_ia[k] = 0; e_wa[k] = 0; e_lay[k] = 0; e_idx[k] = 0; e_bdv[k] = 0; sc_tab[k] = '0;
    end
    best = '0;
    bidx = 0;
    t = 1;
    for (int s = 0; s < NS; s++) begin
      for (int l = 0; l < 2; l++) begin
        int f;
        int nn;
        f  = (l == 1) ? NH : NI;
        nn = (l == 1) ? NO : NH;
        for (int n = 0; n < nn; n++) begin
          for (int i = 0; i < f; i++) begin
            e_mac[t+i] = 1;
            e_ia[t+i]  = (l == 1) ? i : s * NI + i;
            e_wa[t+i]  = (l == 1) ? NH * NI + n * NH + i : n * NI + i;
            e_lay[t+i] = l;
            e_en[t+i+1] = 1;
            if (i == 0) e_clr[t+i+1] = 1;
          end
          e_wr[t+f+2]  = 1;
          e_idx[t+f+2] = n;
          if (l == 1) begin
            sc = pick_score(mode, s, n);
            e_sc[t+f+2]   = 1;
            sc_tab[t+f+2] = sc;
            if (n == 0 || $signed(sc) > best) begin
              best = $signed(sc);
              bidx = n;
            end
          end
          t += f + 3;
        end
      end
      e_bd[t]  = 1;
      e_bdv[t] = bidx;
      t++;
    end
    cur = prev_res;
    for (int k = 0; k < TLEN; k++) begin
      if (e_bd[k]) cur = e_bdv[k];
      e_res[k]  = cur;
      e_busy[k] = (k >= 1) && (k < T_DONE);
      e_done[k] = (k == 0) ? prev_done : (k >= T_DONE);
    end
    exp_final = cur;
  endtask

  // Per-cycle comparison of every output against the run timeline.
  always @(negedge clk) begin
    int t;
    if (chk_on) begin
      t = cyc - run_base;
      if (t >= 0 && t < TLEN - 1) begin
        chk("busy",       t, busy,       e_busy[t]);
        chk("done",       t, done,       e_done[t]);
        chk("mac_en",     t, mac_en,     e_en[t]);
        chk("mac_clr",    t, mac_clr,    e_clr[t]);
        chk("neuron_wr",  t, neuron_wr,  e_wr[t]);
        chk("batch_done", t, batch_done, e_bd[t]);
        chk("result",     t, result,     e_res[t]);
        if (e_mac[t]) begin
          chk("in_addr", t, in_addr, e_ia[t]);
          chk("w_addr",  t, w_addr,  e_wa[t]);
          chk("layer",   t, layer,   e_lay[t]);
        end
        if (e_wr[t]) chk("neuron_idx", t, neuron_idx, e_idx[t]);
        cap_ia[t] = int'(in_addr);
        cap_wa[t] = int'(w_addr);
        if (batch_done === 1'b1) begin
          bd_t.push_back(t);
          bd_r.push_back(int'(result));
        end
        if (done === 1'b1 && done_t < 0) done_t = t;
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_in_addr"},    0, in_addr,    0);
    chk({nm, "_w_addr"},     0, w_addr,     0);
    chk({nm, "_layer"},      0, layer,      0);
    chk({nm, "_mac_clr"},    0, mac_clr,    0);
    chk({nm, "_mac_en"},     0, mac_en,     0);
    chk({nm, "_neuron_idx"}, 0, neuron_idx, 0);
    chk({nm, "_neuron_wr"},  0, neuron_wr,  0);
    chk({nm, "_result"},     0, result,     0);
    chk({nm, "_batch_done"}, 0, batch_done, 0);
    chk({nm, "_busy"},       0, busy,       0);
    chk({nm, "_done"},       0, done,       0);
  endtask

  task automatic run(input int mode);
    build_model(mode);
    bd_t.delete();
    bd_r.delete();
    done_t = -1;
    @(posedge clk); #1;
    run_base = cyc;
    start    = 1'b1;
    score    = SW'($urandom);
    chk_on   = 1'b1;
    for (int t = 1; t < TLEN - 1; t++) begin
      @(posedge clk); #1;
      start = (mode >= 2) && (t == 5 || t == 17 || t == 40 || t == T_DONE - 2);
      score = e_sc[t] ? sc_tab[t] : SW'($urandom);
    end
    @(posedge clk); #1;
    chk_on = 1'b0;
    start  = 1'b0;
    prev_res  = exp_final;
    prev_done = 1'b1;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    score = '0;
    #12;
    chk_zero("rst_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset_state");

    // Directed argmax: {5,-3,5} then {-7,-2,-9}, with literal timing/addresses.
    run(0);
    chk("first_bd_cycle",  0, qget(bd_t, 0), 28);
    chk("second_bd_cycle", 0, qget(bd_t, 1), 56);
    chk("bd_count",        0, bd_t.size(),   2);
    chk("done_cycle",      0, done_t,        57);
    chk("res_tie_low",     0, qget(bd_r, 0), 0);
    chk("res_all_neg",     0, qget(bd_r, 1), 1);
    for (int k = 0; k < 3; k++) begin
      chk("s1_n1_in_addr", 35 + k, cap_ia[35+k], 3 + k);
      chk("s1_n1_w_addr",  35 + k, cap_wa[35+k], 3 + k);
    end
    chk("s0_o2_w_addr", 23, cap_wa[23], 10);
    chk("s0_o2_w_addr", 24, cap_wa[24], 11);

    // Signed extremes: {0x8000,0x7FFF,0}; also a restart after done.
    run(1);
    chk("res_signed_ext", 0, qget(bd_r, 0), 1);

    // Asynchronous reset in the middle of a run.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    chk("midrun_busy", 0, busy, 1);
    rst = 1'b1;
    #1;
    chk_zero("midrun_rst");
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      chk("post_rst_batch_done", k, batch_done, 0);
      chk("post_rst_done",       k, done,       0);
      chk("post_rst_busy",       k, busy,       0);
    end
    prev_res  = 0;
    prev_done = 1'b0;

    // Random scores with stray start pulses while busy, then tie-prone scores.
    run(2);
    run(3);
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
